mips_store_checker: RTL
=======================

// Module: mips_store_checker
// PURPOSE
//  Synthesisable, parametrised store-trace checker for the MIPS CPU test harness; replaces hard-coded negedge pass/fail checks.
//  Snoops the data-memory write port (memwrite/aluout/writedata) and compares stores against a loadable table of expected (addr,data) pairs.
//  Tolerates stores inside a programmable scratch window. Adds a cycle watchdog, a store-count limit and sticky pass/fail plus diagnostics.
//  Usable in simulation benches and on FPGA (pass/fail to LEDs).
// PARAMETERS
//  ADDR_W      32     width of snooped address (aluout)
//  DATA_W      32     width of snooped store data (writedata)
//  DEPTH       8      expected-table entries; index width IDX_W = $clog2(DEPTH+1)
//  ORDERED     1      1: every table entry must occur in order; 0: only entry num_exp-1 is compared, all other stores must hit the window
//  TIMEOUT     4096   RUN cycles before a timeout fail; 0 disables the watchdog
//  MAX_STORES  256    stores accepted before an overflow fail
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       synchronous, active-low reset
//  start       in   1       1-cycle pulse: arm the checker (IDLE/PASS/FAIL -> RUN)
//  num_exp     in   IDX_W   entries in use, sampled on start; legal 1..DEPTH
//  ign_lo      in   ADDR_W  scratch window low bound (inclusive), sampled on start
//  ign_hi      in   ADDR_W  scratch window high bound (inclusive), sampled on start
//  exp_we      in   1       table write strobe
//  exp_idx     in   IDX_W   table write index
//  exp_addr    in   ADDR_W  expected store address
//  exp_data    in   DATA_W  expected store data
//  memwrite    in   1       snooped store strobe
//  aluout      in   ADDR_W  snooped store address
//  writedata   in   DATA_W  snooped store data
//  busy        out  1       state==RUN
//  pass        out  1       sticky: state==PASS
//  fail        out  1       sticky: state==FAIL
//  fail_code   out  3       fail_code_t: 0 NONE, 1 MISMATCH, 2 TIMEOUT, 3 OVERFLOW, 4 BADCFG
//  fail_addr   out  ADDR_W  aluout of the offending store (0 for TIMEOUT/BADCFG)
//  fail_data   out  DATA_W  writedata of the offending store
//  match_cnt   out  IDX_W   table entries matched so far
//  store_cnt   out  9       stores seen in RUN, saturating at 511
// BEHAVIOUR
//  Reset (reset==0 at posedge): state IDLE; all outputs 0; table cleared to 0; watchdog and counters 0. Applies from any state, including mid-RUN.
//  States: IDLE, RUN, PASS, FAIL. All decisions are registered: a store at edge N is reflected in outputs after edge N (1-cycle latency).
//  Table load: exp_we honoured only outside RUN; exp_idx>=DEPTH is ignored. A start in the same cycle as exp_we is ignored; the write still occurs.
//  start (not RUN): num_exp==0 or >DEPTH -> FAIL/BADCFG next cycle. Otherwise -> RUN, clearing match_cnt, store_cnt, watchdog, fail_*.
//  start while in RUN is ignored.
//  RUN, per cycle with memwrite=1, store_cnt++. Priority order:
//   1) (aluout,writedata)==table[match_cnt] (ORDERED) or ==table[num_exp-1] (!ORDERED):
//      match_cnt++; if the last entry matched -> PASS.
//   2) else ign_lo<=aluout<=ign_hi -> accepted, no state change.
//   3) else -> FAIL/MISMATCH, capture aluout/writedata.
//   4) if no PASS/FAIL was taken and store_cnt reaches MAX_STORES -> FAIL/OVERFLOW.
//  Window check is unsigned. ign_lo>ign_hi means an empty window.
//  Watchdog: increments every RUN cycle and resets on start. On reaching TIMEOUT -> FAIL/TIMEOUT.
//  A store match in the same cycle as the timeout wins (PASS).
//  PASS/FAIL are sticky until reset or a new start. memwrite there is ignored and counters freeze.
//  memwrite in IDLE is ignored.
// STRUCTURE
//  Package mips_check_pkg: chk_state_t enum {IDLE,RUN,PASS,FAIL}; fail_code_t enum (3-bit, codes above); FAIL_* localparams.
//  Sub-module mips_expect_table: DEPTH x (ADDR_W+DATA_W) register file, 1 sync write port, 1 combinational read port, sync active-low clear.
//  Top: FSM, window comparator, counters, diagnostic capture registers.
// TESTING
//  T1 ORDERED, num_exp=2, table {(0x54,7),(0x10,0xfffffffa)}, window 0x14..0x28; stores 0x14,(0x54,7),0x20,(0x10,0xfffffffa) -> pass=1 after last, match_cnt=2, store_cnt=4.
//  T2 same table; store (0x80,5) -> fail=1, fail_code=1, fail_addr=0x80, fail_data=5; later stores leave all outputs unchanged.
//  T3 ORDERED=0, num_exp=2; (0x10,0xfffffffa) as the first store -> PASS; entry 0 never checked.
//  T4 TIMEOUT=16, no stores -> fail_code=2 exactly 16 cycles after RUN entry. Then reset low 1 cycle mid-FAIL -> all outputs 0, state IDLE.
//  T5 start with num_exp=0 -> fail_code=4 next cycle. exp_we during RUN -> table unchanged (re-run T1 passes). start coincident with exp_we -> stays IDLE.
//  T6 MAX_STORES=3, all stores in window -> fail_code=3 on the 3rd store. reset asserted mid-RUN -> IDLE, counters 0.

Source files
------------

// File: rtl/mips_check_pkg.sv
// Shared types for the MIPS store-trace checker.
// States, fail codes and their encodings.
package mips_check_pkg;

    localparam logic [2:0] FAIL_NONE     = 3'd0;
    localparam logic [2:0] FAIL_MISMATCH = 3'd1;
    localparam logic [2:0] FAIL_TIMEOUT  = 3'd2;
    localparam logic [2:0] FAIL_OVERFLOW = 3'd3;
    localparam logic [2:0] FAIL_BADCFG   = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PASS,
        FAIL
    } chk_state_t;

    typedef enum logic [2:0] {
        FC_NONE     = FAIL_NONE,
        FC_MISMATCH = FAIL_MISMATCH,
        FC_TIMEOUT  = FAIL_TIMEOUT,
        FC_OVERFLOW = FAIL_OVERFLOW,
        FC_BADCFG   = FAIL_BADCFG
    } fail_code_t;

endpackage

// File: rtl/mips_expect_table.sv
// Expected-store table: one sync write port, one comb read port.
// Out-of-range indices are dropped on write and read back as zero.
module mips_expect_table #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  ridx,
    output logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] DEPTH_V = IDX_W'(DEPTH);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else if (we && (widx < DEPTH_V)) begin
            addr_q[widx[AW-1:0]] <= waddr;
            data_q[widx[AW-1:0]] <= wdata;
        end
    end

    always_comb begin
        raddr = '0;
        rdata = '0;
        if (ridx < DEPTH_V) begin
            raddr = addr_q[ridx[AW-1:0]];
            rdata = data_q[ridx[AW-1:0]];
        end
    end

endmodule

// File: rtl/mips_store_checker.sv
// Store-trace checker: snoops data-memory writes against a table
// of expected stores, with scratch window, watchdog and store limit.
module mips_store_checker
    import mips_check_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 8,
    parameter int ORDERED    = 1,
    parameter int TIMEOUT    = 4096,
    parameter int MAX_STORES = 256,
    localparam int IDX_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [IDX_W-1:0]  num_exp,
    input  logic [ADDR_W-1:0] ign_lo,
    input  logic [ADDR_W-1:0] ign_hi,
    input  logic              exp_we,
    input  logic [IDX_W-1:0]  exp_idx,
    input  logic [ADDR_W-1:0] exp_addr,
    input  logic [DATA_W-1:0] exp_data,
    input  logic              memwrite,
    input  logic [ADDR_W-1:0] aluout,
    input  logic [DATA_W-1:0] writedata,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic [2:0]        fail_code,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [IDX_W-1:0]  match_cnt,
    output logic [8:0]        store_cnt
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0]  TO_V    = WD_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] DEPTH_V = IDX_W'(DEPTH);
    localparam logic [8:0]       MAXS_V  = 9'(MAX_STORES);
    localparam bit               OVF_EN  = (MAX_STORES <= 511);
    localparam bit               WD_EN   = (TIMEOUT != 0);

    chk_state_t        state_q, state_d;
    fail_code_t        code_q;
    logic [IDX_W-1:0]  num_q, match_q;
    logic [ADDR_W-1:0] lo_q, hi_q, faddr_q;
    logic [DATA_W-1:0] fdata_q;
    logic [8:0]        store_q, store_inc;
    logic [WD_W-1:0]   wd_q, wd_inc;

    logic [IDX_W-1:0]  ridx;
    logic [ADDR_W-1:0] t_addr;
    logic [DATA_W-1:0] t_data;
    logic running, arm, bad, st, hit, last, in_win;
    logic ev_pass, ev_mis, ev_ovf, ev_to;

    mips_expect_table #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_table (
        .clk   (clk),
        .reset (reset),
        .we    (exp_we && !running),
        .widx  (exp_idx),
        .waddr (exp_addr),
        .wdata (exp_data),
        .ridx  (ridx),
        .raddr (t_addr),
        .rdata (t_data)
    );

    always_comb begin
        running   = (state_q == RUN);
        arm       = start && !exp_we && !running;
        bad       = (num_exp == '0) || (num_exp > DEPTH_V);
        ridx      = ORDERED != 0 ? match_q : num_q - IDX_W'(1);
        st        = running && memwrite;
        hit       = st && (t_addr == aluout) && (t_data == writedata);
        // unordered mode only ever compares the final entry
        last      = ORDERED != 0 ? (match_q + IDX_W'(1) == num_q) : 1'b1;
        in_win    = (aluout >= lo_q) && (aluout <= hi_q);
        store_inc = (store_q == 9'h1ff) ? store_q : store_q + 9'd1;
        wd_inc    = wd_q + WD_W'(1);
        ev_pass   = hit && last;
        ev_mis    = st && !hit && !in_win;
        ev_ovf    = st && !ev_pass && !ev_mis && OVF_EN
                    && (store_inc == MAXS_V);
        ev_to     = running && WD_EN && (wd_inc == TO_V)
                    && !ev_pass && !ev_mis && !ev_ovf;
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (ev_pass)
                    state_d = PASS;
                else if (ev_mis || ev_ovf || ev_to)
                    state_d = FAIL;
            end
            default: begin
                if (arm) state_d = bad ? FAIL : RUN;
            end
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        pass = (state_q == PASS);
        fail = (state_q == FAIL);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            num_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            match_q <= '0;
            store_q <= '0;
            wd_q    <= '0;
            code_q  <= FC_NONE;
            faddr_q <= '0;
            fdata_q <= '0;
        end else if (arm) begin
            num_q   <= num_exp;
            lo_q    <= ign_lo;
            hi_q    <= ign_hi;
            match_q <= '0;
            store_q <= '0;
            wd_q    <= '0;
            code_q  <= bad ? FC_BADCFG : FC_NONE;
            faddr_q <= '0;
            fdata_q <= '0;
        end else if (running) begin
            wd_q <= wd_inc;
            if (st)  store_q <= store_inc;
            if (hit) match_q <= match_q + IDX_W'(1);
            if (ev_mis || ev_ovf) begin
                code_q  <= ev_mis ? FC_MISMATCH : FC_OVERFLOW;
                faddr_q <= aluout;
                fdata_q <= writedata;
            end else if (ev_to) begin
                code_q <= FC_TIMEOUT;
            end
        end
    end

    assign fail_code = code_q;
    assign fail_addr = faddr_q;
    assign fail_data = fdata_q;
    assign match_cnt = match_q;
    assign store_cnt = store_q;

endmodule
